cos_ctrl: RTL and testbench
===========================

Name: cos_ctrl

Overview:
- FSM controller that sequences the cos(x) Taylor-series datapath: cos(x) = 1 - x^2/2! + x^4/4! - ...
- Drives every load, select, init, counter and toggle strobe of the datapath; consumes its status flags co and ygt_temp.
- Exposes a start/ready/done handshake to the host.
- Sits beside the datapath inside the full-circuit top.

Parameters:
- EARLY_EXIT, 1: 1 = stop when the threshold flag ygt_temp is high in CHECK; 0 = ignore ygt_temp and stop only on co.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- co  input  1  datapath term-counter carry; high when address = 4'hF
- ygt_temp  input  1  datapath flag: Y threshold > current term temp
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; result on datapath ans is valid
- ld_y, init_temp, initseri, izcounter, clr  output  1 each  datapath init strobes
- ldx2, ldtemp, ldseri, cen, Tsignal  output  1 each  datapath load/count/toggle strobes
- slx, slx2, slR, sltemp  output  1 each  datapath one-hot mux selects

Behaviour:
- Moore FSM, all outputs decoded from state, registered state only. Every strobe/select not listed for a state is 0.
- Reset: state = IDLE next edge, regardless of current state (mid-operation included). After reset, ready = 1 and all other outputs = 0.
- Datapath contract:
  - Host holds Xin stable from the start cycle through SQUARE.
  - Yin is captured in LOAD.
  - ROM is synchronous: fact follows the counter address by one cycle.
- States and transitions:
  - IDLE: ready = 1. start = 1 -> LOAD, else stay.
  - LOAD: ld_y, init_temp (temp <= 1.0), initseri (ans <= 0), izcounter (adr <= 0), clr (toggle <= add). -> SQUARE.
  - SQUARE: slx, ldx2 (x2 <= Xin*Xin). ROM[0] becomes valid this cycle. -> ACCUM.
  - ACCUM: ldseri (ans <= ans +/- temp), Tsignal (flip add/sub for the next term).
    - co = 1 -> DONE.
    - else -> MULX2.
  - MULX2: sltemp, slx2, ldtemp (temp <= temp*x2). -> MULR.
  - MULR: sltemp, slR, ldtemp (temp <= temp*ROM[adr]), cen (adr++). -> CHECK.
  - CHECK: no strobes; lets the new temp and ygt_temp settle and the ROM refetch.
    - EARLY_EXIT = 1 and ygt_temp = 1 -> DONE (negligible term is not accumulated).
    - else -> ACCUM.
  - DONE: done = 1 for exactly one cycle. -> IDLE.
- Latency, counted from the cycle start is sampled high in IDLE:
  - LOAD = cycle 1, SQUARE = 2, first ACCUM = 3.
  - Each further term costs 4 cycles (MULX2, MULR, CHECK, ACCUM).
  - Threshold exit after k terms accumulated: done at cycle 3 + 4(k-1) + 4 = 4k + 3.
  - Counter exit: done at the cycle after the ACCUM in which co = 1. With the counter starting at 0, co is reached after 15 cen pulses, i.e. 16 terms, so done at cycle 64.
- Boundary conditions:
  - start high while not IDLE: ignored; no queuing.
  - start held high continuously: a new run begins immediately after DONE -> IDLE. IDLE therefore lasts one cycle and ready pulses for one cycle.
  - co and ygt_temp both high in CHECK (EARLY_EXIT = 1): threshold wins -> DONE.
  - co high in ACCUM: that term is still accumulated (ldseri asserted), then -> DONE.
  - Tsignal asserted in every ACCUM, including the last; harmless because LOAD clears the toggle.
  - Selects are one-hot: at most one of {slx, sltemp} and at most one of {slx, slx2, slR} high in any cycle. The bench asserts this.
  - No illegal-state lockup: any unencoded state -> IDLE next cycle.

Test Plan:
- Reset/idle: rst = 1 for 2 cycles, then 0, start = 0 -> ready = 1, all other outputs 0 for 10 cycles.
- x = 0, stubbed flags ygt_temp = 1, co = 0: start pulse -> LOAD strobes at cycle 1, ldx2+slx at 2, ldseri+Tsignal at 3, MULX2 at 4, MULR with cen at 5, done at cycle 7. Exactly one ldseri seen.
- Threshold exit after 3 terms (ygt_temp driven high only on the third CHECK) -> 3 ldseri pulses, 3 cen pulses, done at cycle 15, ready at cycle 16.
- Counter exit, ygt_temp = 0, co modelled by a 4-bit counter on cen -> 16 ldseri, 15 cen, done at cycle 64. Same run with EARLY_EXIT = 0 and ygt_temp = 1 throughout -> identical result.
- Reset mid-run: rst = 1 during the 2nd MULR -> next cycle IDLE, ready = 1, no done. A following start runs normally from LOAD.
- Start abuse: start held high for 100 cycles with ygt_temp = 1 -> back-to-back runs of 7 cycles + 1 IDLE each. Start pulses during busy produce no extra run. The one-hot select assertion holds every cycle.

Source files
------------

// File: rtl/cos_ctrl.sv
// Sequencing controller for the cos(x) Taylor-series datapath.
// Moore FSM: every strobe and select is decoded from the registered state.
//
// state  | meaning
// IDLE   | waiting for start, ready high
// LOAD   | capture Yin, temp <= 1.0, ans <= 0, adr <= 0, toggle <= add
// SQUARE | x2 <= Xin*Xin; ROM[0] becomes valid
// ACCUM  | ans <= ans +/- temp, flip add/sub for the next term
// MULX2  | temp <= temp*x2
// MULR   | temp <= temp*ROM[adr], adr++
// CHECK  | settle new temp, ygt_temp and ROM refetch
// DONE   | one-cycle done pulse, result valid on ans
module cos_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic co,
    input  logic ygt_temp,
    output logic ready,
    output logic done,
    output logic ld_y,
    output logic init_temp,
    output logic initseri,
    output logic izcounter,
    output logic clr,
    output logic ldx2,
    output logic ldtemp,
    output logic ldseri,
    output logic cen,
    output logic Tsignal,
    output logic slx,
    output logic slx2,
    output logic slR,
    output logic sltemp
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SQUARE = 3'd2,
        S_ACCUM  = 3'd3,
        S_MULX2  = 3'd4,
        S_MULR   = 3'd5,
        S_CHECK  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        ready     = 1'b0;
        done      = 1'b0;
        ld_y      = 1'b0;
        init_temp = 1'b0;
        initseri  = 1'b0;
        izcounter = 1'b0;
        clr       = 1'b0;
        ldx2      = 1'b0;
        ldtemp    = 1'b0;
        ldseri    = 1'b0;
        cen       = 1'b0;
        Tsignal   = 1'b0;
        slx       = 1'b0;
        slx2      = 1'b0;
        slR       = 1'b0;
        sltemp    = 1'b0;
        case (state)
            S_IDLE: begin
                ready     = 1'b1;
                state_nxt = start ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                ld_y      = 1'b1;
                init_temp = 1'b1;
                initseri  = 1'b1;
                izcounter = 1'b1;
                clr       = 1'b1;
                state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
                slx       = 1'b1;
                ldx2      = 1'b1;
                state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                // the term is accumulated even when co ends the series here
                ldseri    = 1'b1;
                Tsignal   = 1'b1;
                state_nxt = co ? S_DONE : S_MULX2;
            end
            S_MULX2: begin
                sltemp    = 1'b1;
                slx2      = 1'b1;
                ldtemp    = 1'b1;
                state_nxt = S_MULR;
            end
            S_MULR: begin
                sltemp    = 1'b1;
                slR       = 1'b1;
                ldtemp    = 1'b1;
                cen       = 1'b1;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // a negligible term is dropped rather than accumulated
                state_nxt = (EARLY_EXIT && ygt_temp) ? S_DONE : S_ACCUM;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cos_ctrl.sv
// Self-checking bench for cos_ctrl: a cycle schedule derived from the term
// count is compared against both early-exit and counter-only variants.
module tb_cos_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // output vector order:
    // ready done ld_y init_temp initseri izcounter clr ldx2 ldtemp ldseri cen Tsignal slx slx2 slR sltemp
    localparam logic [15:0] E_IDLE   = 16'b1000_0000_0000_0000;
    localparam logic [15:0] E_DONE   = 16'b0100_0000_0000_0000;
    localparam logic [15:0] E_LOAD   = 16'b0011_1110_0000_0000;
    localparam logic [15:0] E_SQUARE = 16'b0000_0001_0000_1000;
    localparam logic [15:0] E_ACCUM  = 16'b0000_0000_0101_0000;
    localparam logic [15:0] E_MULX2  = 16'b0000_0000_1000_0101;
    localparam logic [15:0] E_MULR   = 16'b0000_0000_1010_0011;
    localparam logic [15:0] E_CHECK  = 16'b0000_0000_0000_0000;

    // early-exit DUT
    logic start1 = 1'b0, co1, ygt1, ygt_force1 = 1'b0;
    logic [4:0] thr_k1 = 5'd17;
    logic [3:0] adr1;
    logic ready1, done1, ld_y1, init_temp1, initseri1, izcounter1, clr1;
    logic ldx21, ldtemp1, ldseri1, cen1, Tsignal1, slx1, slx21, slR1, sltemp1;
    logic [15:0] vec1;

    // counter-only DUT
    logic start0 = 1'b0, co0, ygt0;
    logic [3:0] adr0;
    logic ready0, done0, ld_y0, init_temp0, initseri0, izcounter0, clr0;
    logic ldx20, ldtemp0, ldseri0, cen0, Tsignal0, slx0, slx20, slR0, sltemp0;
    logic [15:0] vec0;

    cos_ctrl #(.EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start1), .co(co1), .ygt_temp(ygt1),
        .ready(ready1), .done(done1), .ld_y(ld_y1), .init_temp(init_temp1),
        .initseri(initseri1), .izcounter(izcounter1), .clr(clr1), .ldx2(ldx21),
        .ldtemp(ldtemp1), .ldseri(ldseri1), .cen(cen1), .Tsignal(Tsignal1),
        .slx(slx1), .slx2(slx21), .slR(slR1), .sltemp(sltemp1));

    cos_ctrl #(.EARLY_EXIT(1'b0)) dut_noexit (
        .clk(clk), .rst(rst), .start(start0), .co(co0), .ygt_temp(ygt0),
        .ready(ready0), .done(done0), .ld_y(ld_y0), .init_temp(init_temp0),
        .initseri(initseri0), .izcounter(izcounter0), .clr(clr0), .ldx2(ldx20),
        .ldtemp(ldtemp0), .ldseri(ldseri0), .cen(cen0), .Tsignal(Tsignal0),
        .slx(slx0), .slx2(slx20), .slR(slR0), .sltemp(sltemp0));

    assign vec1 = {ready1, done1, ld_y1, init_temp1, initseri1, izcounter1, clr1, ldx21,
                   ldtemp1, ldseri1, cen1, Tsignal1, slx1, slx21, slR1, sltemp1};
    assign vec0 = {ready0, done0, ld_y0, init_temp0, initseri0, izcounter0, clr0, ldx20,
                   ldtemp0, ldseri0, cen0, Tsignal0, slx0, slx20, slR0, sltemp0};

    // datapath stand-in: term address counter, carry at 4'hF, threshold reached after thr_k terms
    always @(posedge clk) begin
        if (rst || izcounter1) adr1 <= 4'd0;
        else if (cen1)         adr1 <= adr1 + 4'd1;
        if (rst || izcounter0) adr0 <= 4'd0;
        else if (cen0)         adr0 <= adr0 + 4'd1;
    end
    assign co1  = (adr1 == 4'hF);
    assign co0  = (adr0 == 4'hF);
    assign ygt1 = ygt_force1 | ({1'b0, adr1} >= thr_k1);
    assign ygt0 = 1'b1;

    // one-hot select invariant, every cycle on both instances
    always @(negedge clk) begin
        if (!rst) begin
            total = total + 1;
            if ((32'(slx1) + 32'(sltemp1) > 1) || (32'(slx1) + 32'(slx21) + 32'(slR1) > 1) ||
                (32'(slx0) + 32'(sltemp0) > 1) || (32'(slx0) + 32'(slx20) + 32'(slR0) > 1))
                $display("FAIL onehot_sel: got sel1=%b%b%b%b sel0=%b%b%b%b required at most one per mux",
                         slx1, slx21, slR1, sltemp1, slx0, slx20, slR0, sltemp0);
            else passed = passed + 1;
        end
    end

    // Expected outputs at cycle c of a run whose done pulse lands on cycle d.
    function automatic logic [15:0] exp_vec(int c, int d);
        if (c == 0 || c > d) return E_IDLE;
        if (c == d) return E_DONE;
        if (c == 1) return E_LOAD;
        if (c == 2) return E_SQUARE;
        case ((c - 3) % 4)
            0:       return E_ACCUM;
            1:       return E_MULX2;
            2:       return E_MULR;
            default: return E_CHECK;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total = total + 1;
            if (vec1 !== E_IDLE || vec0 !== E_IDLE)
                $display("FAIL reset_idle: got %h/%h required %h", vec1, vec0, E_IDLE);
            else passed = passed + 1;
        end
    endtask

    // One run: threshold exit after k terms (k <= 15, early-exit DUT) else 16-term counter exit.
    task automatic run_check(input string name, input int k, input bit use0, input bit noise);
        int d, nt, nc, n_ld, n_cen, done_at;
        logic [15:0] v;
        if (!use0 && k <= 15) begin d = 4 * k + 3; nt = k; nc = k; end
        else                  begin d = 64;        nt = 16; nc = 15; end
        n_ld = 0; n_cen = 0; done_at = -1;
        @(negedge clk);
        v = use0 ? vec0 : vec1;
        total = total + 1;
        if (v !== E_IDLE) $display("FAIL %s_idle0: got %h required %h", name, v, E_IDLE);
        else passed = passed + 1;
        if (use0) start0 = 1'b1; else start1 = 1'b1;
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            v = use0 ? vec0 : vec1;
            total = total + 1;
            if (v !== exp_vec(c, d))
                $display("FAIL %s_c%0d: got %h required %h", name, c, v, exp_vec(c, d));
            else passed = passed + 1;
            if (v[6]) n_ld++;
            if (v[5]) n_cen++;
            if (v[14] && done_at < 0) done_at = c;
            start0 = use0 && noise && c <= d ? 1'($urandom_range(0, 1)) : 1'b0;
            start1 = !use0 && noise && c <= d ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        total = total + 3;
        if (n_ld !== nt) $display("FAIL %s_ldseri: got %0d required %0d", name, n_ld, nt);
        else passed = passed + 1;
        if (n_cen !== nc) $display("FAIL %s_cen: got %0d required %0d", name, n_cen, nc);
        else passed = passed + 1;
        if (done_at !== d) $display("FAIL %s_done_cycle: got %0d required %0d", name, done_at, d);
        else passed = passed + 1;
    endtask

    task automatic test_single_term();
        ygt_force1 = 1'b1;
        run_check("single_term", 1, 1'b0, 1'b0);
        ygt_force1 = 1'b0;
    endtask

    task automatic test_three_terms();
        thr_k1 = 5'd3;
        run_check("three_terms", 3, 1'b0, 1'b0);
    endtask

    task automatic test_counter_exit();
        thr_k1 = 5'd17;
        run_check("counter_exit", 17, 1'b0, 1'b0);
        run_check("counter_noexit", 17, 1'b1, 1'b0);
        thr_k1 = 5'd15;
        run_check("co_and_ygt", 15, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        thr_k1 = 5'd3;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            total = total + 1;
            if (vec1 !== exp_vec(c, 15))
                $display("FAIL midrun_c%0d: got %h required %h", c, vec1, exp_vec(c, 15));
            else passed = passed + 1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total = total + 1;
            if (vec1 !== E_IDLE) $display("FAIL midrun_reset_idle: got %h required %h", vec1, E_IDLE);
            else passed = passed + 1;
        end
        run_check("after_reset", 3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int k;
            bit u0, nz;
            k  = int'($urandom_range(1, 17));
            u0 = ($urandom_range(0, 3) == 0);
            nz = 1'($urandom_range(0, 1));
            thr_k1 = 5'(k);
            run_check($sformatf("rand%0d", r), k, u0, nz);
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        n_done = 0;
        ygt_force1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            if (c == 100) start1 = 1'b0;
            total = total + 1;
            if (vec1 !== exp_vec(c <= 103 ? c % 8 : 0, 7))
                $display("FAIL b2b_c%0d: got %h required %h", c, vec1, exp_vec(c <= 103 ? c % 8 : 0, 7));
            else passed = passed + 1;
            if (done1) n_done++;
        end
        total = total + 1;
        if (n_done !== 13) $display("FAIL b2b_done_count: got %0d required 13", n_done);
        else passed = passed + 1;
        ygt_force1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_term();
        test_three_terms();
        test_counter_exit();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
